cc_egr_req_responder: RTL and testbench

// - Responder end of the egress req/resp/data protocol. Accepts one request on req, grants
//   min(requested, available) bytes, returns one resp, then streams ceil(grant/64) 512-bit beats.
// - Sits between the egress request initiator and the per-connection source buffer. Its outputs
//   are the resp/data traffic that the egress protocol checker observes.

---
 rtl/cc_egr_pkg.sv | 13 +
 rtl/cc_egr_beat_counter.sv | 21 ++
 rtl/cc_egr_req_responder.sv | 89 ++++++++
 tb/tb_cc_egr_req_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cc_egr_pkg.sv
// cc_egr_pkg: shared field offsets, state type and beat arithmetic for the egress req/resp protocol.
package cc_egr_pkg;
  localparam int REQ_CH_LSB  = 0;
  localparam int REQ_SOF_BIT = 32;
  localparam int REQ_EOF_BIT = 33;
  localparam int REQ_LEN_LSB = 48;
  localparam int BEAT_BYTES  = 64;
  typedef enum logic [1:0] {IDLE, CALC, RESP, DATA} state_e;
  // Computed at 17 bits so a 16-bit length near 64K cannot wrap while rounding up.
  function automatic logic [16:0] beats_of(input logic [15:0] len, input int unsigned bb = BEAT_BYTES);
    return 17'(({1'b0, len} + 17'(bb - 1)) / 17'(bb));
  endfunction
endpackage

// File: rtl/cc_egr_beat_counter.sv
// cc_egr_beat_counter: remaining-beat counter with load, decrement-on-handshake and last flag.
module cc_egr_beat_counter (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        load,
  input  logic [16:0] load_val,
  input  logic        dec,
  output logic [16:0] cnt,
  output logic        last
);
  logic [16:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : dec ? cnt_q - 17'd1 : cnt_q;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt  = cnt_q;
  assign last = cnt_q == 17'd1;
endmodule

// File: rtl/cc_egr_req_responder.sv
// cc_egr_req_responder: grants min(requested, available) bytes, answers with one resp, then passes the granted beats through.
module cc_egr_req_responder
  import cc_egr_pkg::*;
#(
  parameter logic [15:0] MAX_BURST  = 16'd32768,
  parameter int          BEAT_BYTES = 64
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         req_tvalid,
  output logic         req_tready,
  input  logic [63:0]  req_tdata,
  input  logic [31:0]  src_avail_bytes,
  input  logic         src_tvalid,
  output logic         src_tready,
  input  logic [511:0] src_tdata,
  output logic         resp_tvalid,
  input  logic         resp_tready,
  output logic [63:0]  resp_tdata,
  output logic         data_tvalid,
  input  logic         data_tready,
  output logic [511:0] data_tdata,
  output logic [1:0]   req_error,
  output logic         req_error_vld
);
  state_e      state_q, state_d;
  logic [63:0] req_q, req_d, resp_q, resp_d;
  logic [1:0]  err_q, err_d;
  logic        err_vld_q, err_vld_d, rdy_q, rdy_d;
  logic [15:0] len_in, len, grant;
  logic        req_hs, data_hs, last;
  logic [16:0] cnt;
  always_comb begin
    len_in    = req_tdata[REQ_LEN_LSB +: 16];
    len       = req_q[REQ_LEN_LSB +: 16];
    req_hs    = rdy_q && req_tvalid;
    data_hs   = data_tvalid && data_tready;
    grant     = (err_q != 2'b00) ? 16'd0 : ({16'd0, len} <= src_avail_bytes) ? len : src_avail_bytes[15:0];
    req_d     = req_hs ? req_tdata : req_q;
    err_d     = req_hs ? {len_in > MAX_BURST, len_in == 16'd0} : err_q;
    err_vld_d = req_hs && (len_in == 16'd0 || len_in > MAX_BURST);
    resp_d    = (state_q == CALC) ? {grant, req_q[47:0]} : resp_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = req_hs ? CALC : IDLE;
      CALC:    state_d = RESP;
      RESP:    state_d = !resp_tready ? RESP : (resp_q[63:48] == 16'd0) ? IDLE : DATA;
      default: state_d = (data_hs && last) ? IDLE : DATA;
    endcase
    rdy_d = state_d == IDLE;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      resp_q    <= '0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
      rdy_q     <= rdy_d;
    end
  end
  cc_egr_beat_counter u_cnt (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .load     (state_q == CALC),
    .load_val (beats_of(grant, BEAT_BYTES)),
    .dec      (data_hs),
    .cnt      (cnt),
    .last     (last)
  );
  // Data path is a pure pass-through; only the handshake is gated by state.
  assign req_tready    = rdy_q;
  assign resp_tvalid   = state_q == RESP;
  assign resp_tdata    = resp_q;
  assign data_tvalid   = (state_q == DATA) && src_tvalid;
  assign src_tready    = (state_q == DATA) && data_tready;
  assign data_tdata    = src_tdata;
  assign req_error     = err_q;
  assign req_error_vld = err_vld_q;
  logic unused_cnt;
  assign unused_cnt = |cnt;
endmodule

// File: tb/tb_cc_egr_req_responder.sv
// tb_cc_egr_req_responder: directed scoreboard bench for the egress request responder.
module tb_cc_egr_req_responder;
  localparam logic [15:0] MAXB = 16'd32768;
  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         req_tvalid = 1'b0, req_tready;
  logic [63:0]  req_tdata = '0;
  logic [31:0]  src_avail_bytes = '0;
  logic         src_tvalid = 1'b0, src_tready;
  logic [511:0] src_tdata;
  logic         resp_tvalid, resp_tready = 1'b0;
  logic [63:0]  resp_tdata;
  logic         data_tvalid, data_tready = 1'b0;
  logic [511:0] data_tdata;
  logic [1:0]   req_error;
  logic         req_error_vld;
  int           checks = 0, errors = 0;
  logic [31:0]  src_seq = '0;
  logic [63:0]  resp_sb[$];
  logic [511:0] beat_sb[$];

  assign src_tdata = {16{src_seq}};
  always #5 ap_clk = ~ap_clk;

  cc_egr_req_responder #(.MAX_BURST(MAXB), .BEAT_BYTES(64)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .src_avail_bytes(src_avail_bytes),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .req_error(req_error), .req_error_vld(req_error_vld)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [15:0] len, input logic [15:0] ch, input logic sof, input logic eof,
                           input logic [31:0] avail, input int stall);
    logic [1:0]  err;
    logic [15:0] g;
    logic [16:0] nb;
    logic [63:0] d, exp_resp;
    int          w;
    d        = '0;
    d[15:0]  = ch;
    d[31:16] = 16'hBEEF;
    d[32]    = sof;
    d[33]    = eof;
    d[63:48] = len;
    err = {len > MAXB, len == 16'd0};
    if (err != 2'b00) g = 16'd0;
    else if (avail >= {16'd0, len}) g = len;
    else g = avail[15:0];
    nb = 17'(({1'b0, g} + 17'd63) / 17'd64);
    resp_sb.push_back({g, d[47:0]});
    for (int k = 0; k < int'(nb); k++) beat_sb.push_back({16{src_seq + 32'(k)}});
    w = 0;
    @(negedge ap_clk);
    while (!req_tready && w < 20) begin
      @(negedge ap_clk);
      w++;
    end
    chk("req_tready_wait", 512'(req_tready), 512'(1'b1));
    req_tdata = d; req_tvalid = 1'b1; src_avail_bytes = avail;
    src_tvalid = 1'b1; data_tready = 1'b1; resp_tready = 1'b0;
    @(posedge ap_clk); #1;
    req_tvalid = 1'b0; req_tdata = '1;
    @(negedge ap_clk);
    chk("err_vld_calc", 512'(req_error_vld), 512'(err != 2'b00));
    if (err != 2'b00) chk("req_error", 512'(req_error), 512'(err));
    chk("resp_early", 512'(resp_tvalid), 512'(1'b0));
    @(posedge ap_clk); #1;
    src_avail_bytes = '0;
    @(negedge ap_clk);
    exp_resp = resp_sb.pop_front();
    chk("resp_valid", 512'(resp_tvalid), 512'(1'b1));
    chk("resp_data", 512'(resp_tdata), 512'(exp_resp));
    chk("err_vld_drop", 512'(req_error_vld), 512'(1'b0));
    chk("data_before_resp", 512'(data_tvalid), 512'(1'b0));
    for (int i = 0; i < stall; i++) begin
      @(negedge ap_clk);
      chk("resp_stable", {447'(0), resp_tvalid, resp_tdata}, {447'(0), 1'b1, exp_resp});
    end
    resp_tready = 1'b1;
    @(posedge ap_clk); #1;
    resp_tready = 1'b0;
    if (nb == 17'd0) begin
      @(negedge ap_clk);
      chk("rdy_after_resp", 512'(req_tready), 512'(1'b1));
      chk("no_data_zero", 512'(data_tvalid), 512'(1'b0));
    end
  endtask

  task automatic data_beats(input int n, input int gap);
    int got = 0, cyc = 0;
    bit hs;
    src_tvalid  = ($urandom_range(99) >= gap);
    data_tready = ($urandom_range(99) >= gap);
    if (gap == 0) begin
      @(negedge ap_clk);
      chk("first_beat_lat", 512'(data_tvalid), 512'(1'b1));
      chk("src_ready_pass", 512'(src_tready), 512'(1'b1));
    end
    while (got < n && cyc < 4000) begin
      if (cyc > 0 || gap != 0) @(negedge ap_clk);
      cyc++;
      hs = data_tvalid && data_tready;
      if (hs) begin
        chk("beat", data_tdata, beat_sb.pop_front());
        got++;
      end
      @(posedge ap_clk); #1;
      if (hs) src_seq++;
      if (hs || !src_tvalid) src_tvalid = ($urandom_range(99) >= gap);
      data_tready = ($urandom_range(99) >= gap);
    end
    chk("beat_count", 512'(got), 512'(n));
  endtask

  task automatic finish_data();
    src_tvalid = 1'b1; data_tready = 1'b1;
    @(negedge ap_clk);
    chk("rdy_after_data", 512'(req_tready), 512'(1'b1));
    chk("no_extra_beat", 512'(data_tvalid), 512'(1'b0));
    chk("sb_empty", 512'(beat_sb.size()), 512'(0));
  endtask

  initial begin
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_outputs", 512'({req_tready, resp_tvalid, data_tvalid, src_tready, resp_tdata, req_error, req_error_vld}), 512'(0));
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    start_req(16'd256, 16'd5, 1'b1, 1'b1, 32'd1000, 0);
    data_beats(4, 0);
    finish_data();
    start_req(16'd200, 16'd9, 1'b1, 1'b0, 32'd100, 0);
    data_beats(2, 0);
    finish_data();
    start_req(16'd64, 16'd2, 1'b0, 1'b1, 32'd0, 0);
    start_req(16'd0, 16'd1, 1'b1, 1'b1, 32'd1000, 0);
    start_req(MAXB + 16'd1, 16'd4, 1'b0, 1'b0, 32'd100000, 0);
    start_req(16'd128, 16'd7, 1'b0, 1'b0, 32'd5000, 5);
    data_beats(2, 0);
    finish_data();
    start_req(16'd1000, 16'd3, 1'b1, 1'b1, 32'h0001_0000, 0);
    data_beats(16, 40);
    finish_data();
    start_req(16'd65, 16'd8, 1'b1, 1'b0, 32'd65, 0);
    data_beats(2, 0);
    finish_data();
    start_req(MAXB, 16'hFFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 0);
    data_beats(512, 0);
    finish_data();
    start_req(16'd256, 16'd6, 1'b1, 1'b1, 32'd1000, 0);
    data_beats(2, 0);
    ap_rst = 1'b1; src_tvalid = 1'b1; data_tready = 1'b1;
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("rst_mid_data", 512'({req_tready, resp_tvalid, data_tvalid, src_tready, resp_tdata, req_error, req_error_vld}), 512'(0));
    beat_sb.delete();
    ap_rst = 1'b0;
    start_req(16'd256, 16'd5, 1'b1, 1'b1, 32'd1000, 0);
    data_beats(4, 0);
    finish_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
